// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: 32-cycle iterative MULT/DIV sequencer with HI/LO strobes and stall interlock (define MULDIV_SIGNED_EN for signed MIPS semantics)
module muldiv_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        mfhilo,
  output logic        busy,
  output logic        stall,
  output logic        hien,
  output logic        loen,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        done
);
  typedef enum logic [1:0] {IDLE, RUN, WB} state_t;
  state_t      state;
  logic [4:0]  count;
  logic        opr;
  logic [31:0] mc, hacc, lacc;
  logic [31:0] am, bm, nh, nl, fh, fl;
  logic [32:0] sum, r, t;
  assign busy  = state != IDLE;
  assign stall = busy & (start | mfhilo);
`ifdef MULDIV_SIGNED_EN
  logic        sgn, rsg, bz;
  logic [63:0] prod;
  assign am   = a[31] ? -a : a;
  assign bm   = b[31] ? -b : b;
  assign prod = sgn ? -{nh, nl} : {nh, nl};
  assign fh   = opr ? (rsg ? -nh : nh) : prod[63:32];
  assign fl   = opr ? ((sgn & ~bz) ? -nl : nl) : prod[31:0];
`else
  assign am = a;
  assign bm = b;
  assign fh = nh;
  assign fl = nl;
`endif
  // One iteration: shift-add step for MULT, restoring shift/trial-subtract step for DIV
  always_comb begin
    sum = {1'b0, hacc} + (lacc[0] ? {1'b0, mc} : 33'd0);
    r   = {hacc, lacc[31]};
    t   = r - {1'b0, mc};
    nh  = opr ? (t[32] ? r[31:0] : t[31:0]) : sum[32:1];
    nl  = opr ? {lacc[30:0], ~t[32]} : {sum[0], lacc[31:1]};
  end
  // Sequencer: latch operands in IDLE, iterate 32 times in RUN, strobe results for one WB cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      count <= '0;
      opr   <= 1'b0;
      mc    <= '0;
      hacc  <= '0;
      lacc  <= '0;
      hien  <= 1'b0;
      loen  <= 1'b0;
      done  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
`ifdef MULDIV_SIGNED_EN
      sgn   <= 1'b0;
      rsg   <= 1'b0;
      bz    <= 1'b0;
`endif
    end else begin
      hien <= 1'b0;
      loen <= 1'b0;
      done <= 1'b0;
      if (state == IDLE && start) begin
        state <= RUN;
        count <= 5'd31;
        opr   <= op;
        mc    <= op ? bm : am;
        lacc  <= op ? am : bm;
        hacc  <= '0;
`ifdef MULDIV_SIGNED_EN
        sgn   <= a[31] ^ b[31];
        rsg   <= a[31];
        bz    <= b == '0;
`endif
      end else if (state == RUN) begin
        hacc  <= nh;
        lacc  <= nl;
        count <= count - 5'd1;
        if (count == '0) begin
          state <= WB;
          hi    <= fh;
          lo    <= fl;
          hien  <= 1'b1;
          loen  <= 1'b1;
          done  <= 1'b1;
        end
      end else if (state == WB) begin
        state <= IDLE;
      end
    end
  end
endmodule
